// File: rtl/ula_arbiter.sv
// Two-requester round-robin front end for the shared ULA: grants one request,
// holds its operands on the ULA inputs, and captures the result after one clock.
module ula_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             done0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             done1,
  output logic [WIDTH-1:0] res,
  output logic             res_zero,
  output logic             busy,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [1:0]       ula_op,
  input  logic [WIDTH-1:0] ula_result,
  input  logic             ula_zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;

  // A requester is not eligible in the cycle its own done is high.
  logic elig0, elig1, grant;
  assign elig0 = req0 & ~done0_q;
  assign elig1 = req1 & ~done1_q;
  assign grant = (elig0 & elig1) ? ~last_q : elig1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (elig0 | elig1) begin
          gnt_d   = grant;
          last_d  = grant;
          op_d    = grant ? op1 : op0;
          a_d     = grant ? a1 : a0;
          b_d     = grant ? b1 : b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        res_d   = ula_result;
        zero_d  = ula_zero;
        done0_d = ~gnt_q;
        done1_d = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      op_q    <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign done0    = done0_q;
  assign done1    = done1_q;
  assign res      = res_q;
  assign res_zero = zero_q;
  assign busy     = (state_q != S_IDLE);
  assign ula_a    = a_q;
  assign ula_b    = b_q;
  assign ula_op   = op_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: behavioural ULA plus a cycle-count reference model
// of the arbitration rules; directed scenarios followed by random traffic.
module tb_ula_arbiter;

  logic       c = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       done0, done1;
  logic [7:0] res;
  logic       res_zero, busy;
  logic [7:0] ula_a, ula_b;
  logic [1:0] ula_op;
  logic [7:0] ula_result;
  logic       ula_zero;

  int checks = 0;
  int errors = 0;

  always #5 c = ~c;

  ula_arbiter #(.WIDTH(8)) dut (
    .c(c), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .done0(done0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .done1(done1),
    .res(res), .res_zero(res_zero), .busy(busy),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_result(ula_result), .ula_zero(ula_zero)
  );

  function automatic logic [7:0] ula_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (op)
      2'b00:   r = (int'(a) + int'(b)) % 256;
      2'b01:   r = (int'(a) - int'(b) + 256) % 256;
      2'b10:   r = (a != 0 && b != 0) ? 1 : 0;
      default: r = (a != 0 || b != 0) ? 1 : 0;
    endcase
    return r[7:0];
  endfunction

  // Shared ULA: one-clock registered result.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      ula_result <= 8'h00;
      ula_zero   <= 1'b0;
    end else begin
      ula_result <= ula_fn(ula_op, ula_a, ula_b);
      ula_zero   <= (ula_fn(ula_op, ula_a, ula_b) == 8'h00);
    end
  end

  // Reference model: cycles_left counts down the remaining ISSUE/WAIT cycles.
  int         cycles_left;
  logic       m_last, m_gnt, m_done0, m_done1, m_zero;
  logic [7:0] m_res, m_pend, m_ua, m_ub;
  logic [1:0] m_uop;

  task automatic model_reset();
    cycles_left = 0;
    m_last = 1'b1; m_gnt = 1'b0;
    m_done0 = 1'b0; m_done1 = 1'b0;
    m_res = 8'h00; m_zero = 1'b0; m_pend = 8'h00;
    m_ua = 8'h00; m_ub = 8'h00; m_uop = 2'b00;
  endtask

  task automatic model_edge();
    logic nd0, nd1, e0, e1;
    nd0 = 1'b0; nd1 = 1'b0;
    if (cycles_left == 0) begin
      e0 = req0 && !m_done0;
      e1 = req1 && !m_done1;
      if (e0 || e1) begin
        m_gnt  = (e0 && e1) ? !m_last : e1;
        m_last = m_gnt;
        m_uop  = m_gnt ? op1 : op0;
        m_ua   = m_gnt ? a1 : a0;
        m_ub   = m_gnt ? b1 : b0;
        m_pend = ula_fn(m_uop, m_ua, m_ub);
        cycles_left = 2;
      end
    end else if (cycles_left == 2) begin
      cycles_left = 1;
    end else begin
      cycles_left = 0;
      m_res  = m_pend;
      m_zero = (m_pend == 8'h00);
      if (m_gnt) nd1 = 1'b1; else nd0 = 1'b1;
    end
    m_done0 = nd0;
    m_done1 = nd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("done0",    32'(done0),    32'(m_done0));
    chk("done1",    32'(done1),    32'(m_done1));
    chk("busy",     32'(busy),     32'(cycles_left != 0));
    chk("res",      32'(res),      32'(m_res));
    chk("res_zero", 32'(res_zero), 32'(m_zero));
    chk("ula_a",    32'(ula_a),    32'(m_ua));
    chk("ula_b",    32'(ula_b),    32'(m_ub));
    chk("ula_op",   32'(ula_op),   32'(m_uop));
    chk("one_hot_done", 32'(done0 & done1), 32'd0);
    if (done0 || done1)
      $display("txn: done%0d res=%02h zero=%b t=%0t", done1 ? 1 : 0, res, res_zero, $time);
  endtask

  task automatic cycle();
    @(posedge c);
    if (rst_n) model_edge();
    @(negedge c);
    check_all();
  endtask

  // Called just after a negedge: asynchronous assert mid-cycle, held one edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int who, input logic [7:0] exp_res, input logic exp_zero,
                           input string tag, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      n++;
      if ((who == 0) ? done0 : done1) begin
        found = 1'b1;
        chk({tag, "_res"},  32'(res),      32'(exp_res));
        chk({tag, "_zero"}, 32'(res_zero), 32'(exp_zero));
        chk({tag, "_other_done"}, 32'((who == 0) ? done1 : done0), 32'd0);
      end
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    int n;
    int seq[$];
    rst_n = 1'b0;
    req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    model_reset();
    @(negedge c);
    check_all();
    rst_n = 1'b1;
    cycle();

    // Single request with its latency
    req0 = 1; op0 = 2'b00; a0 = 8'h04; b0 = 8'h01;
    wait_done(0, 8'h05, 1'b0, "single", n);
    chk("single_latency", 32'(n), 32'd3);
    req0 = 0;
    cycle();

    // Asynchronous reset asserted mid-cycle while idle with captured state
    do_reset();

    // Tie right after reset: requester 0 first, requester 1 three cycles later
    req0 = 1; op0 = 2'b01; a0 = 8'h03; b0 = 8'h03;
    req1 = 1; op1 = 2'b00; a1 = 8'hFF; b1 = 8'h02;
    wait_done(0, 8'h00, 1'b1, "tie0", n);
    chk("tie0_latency", 32'(n), 32'd3);
    req0 = 0;
    wait_done(1, 8'h01, 1'b0, "tie1", n);
    chk("tie1_latency", 32'(n), 32'd3);
    req1 = 0;
    cycle();

    // Fairness: both held high for 12 cycles
    do_reset();
    req0 = 1; op0 = 2'b00; a0 = 8'h10; b0 = 8'h01;
    req1 = 1; op1 = 2'b01; a1 = 8'h50; b1 = 8'h20;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (done0) seq.push_back(0);
      if (done1) seq.push_back(1);
    end
    req0 = 0; req1 = 0;
    chk("fair_count", 32'(seq.size()), 32'd4);
    for (int i = 0; i < seq.size(); i++)
      chk("fair_order", 32'(seq[i]), 32'(i % 2));
    cycle();

    // Operands changed after the grant have no effect
    req0 = 1; op0 = 2'b00; a0 = 8'h10; b0 = 8'h01;
    cycle();
    a0 = 8'h20;
    wait_done(0, 8'h11, 1'b0, "stable", n);
    req0 = 0;
    cycle();

    // Reset during ISSUE aborts the operation; requester 1 then served normally
    req0 = 1; op0 = 2'b00; a0 = 8'h33; b0 = 8'h44;
    cycle();
    chk("abort_busy", 32'(busy), 32'd1);
    do_reset();
    req0 = 0;
    req1 = 1; op1 = 2'b11; a1 = 8'h00; b1 = 8'h05;
    wait_done(1, 8'h01, 1'b0, "after_abort", n);
    req1 = 0;
    cycle();

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) != 0);
      op0 = 2'($urandom_range(0, 3));
      op1 = 2'($urandom_range(0, 3));
      a0 = 8'($urandom_range(0, 255));
      b0 = ($urandom_range(0, 3) == 0) ? a0 : 8'($urandom_range(0, 255));
      a1 = 8'($urandom_range(0, 255));
      b1 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
